// File: rtl/alu_issue_ctrl.sv
// Issue stage for the FP ALU: command FIFO, per-op latency hold, in-order valid/ready response.
// Optional divide-by-zero short-cut enabled by defining ALU_DIV_ZERO_CHK_EN.
module alu_issue_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LAT_ADD    = 2,
    parameter int unsigned LAT_MUL    = 3,
    parameter int unsigned LAT_DIV    = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [31:0] alu_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_c,
    output logic [1:0]  rsp_op,
    output logic        rsp_err
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
`ifdef ALU_DIV_ZERO_CHK_EN
    localparam logic DZ_EN = 1'b1;
`else
    localparam logic DZ_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DZ, S_RESP} state_t;

    cmd_t               fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0]  count_q;
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        alu_a_q, alu_b_q, rsp_c_q;
    logic [1:0]         alu_op_q, rsp_op_q;
    logic               rsp_valid_q, rsp_err_q;

    logic               push_c, pop_c, empty_c, dz_c;
    cmd_t               head_c;
    logic [CNT_W-1:0]   lat_c;

    assign cmd_ready = (count_q != FULL_CNT);
    assign empty_c   = (count_q == '0);
    assign push_c    = cmd_valid & cmd_ready;
    assign head_c    = fifo_q[rd_ptr_q];
    assign pop_c     = !empty_c &&
                       ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
    assign dz_c      = DZ_EN && (head_c.op == 2'b11) && (head_c.b[30:0] == 31'd0);

    // Counter preload: cycles remaining after the issue cycle.
    always_comb begin
        lat_c = CNT_W'(LAT_ADD - 1);
        case (head_c.op)
            2'b10:   lat_c = CNT_W'(LAT_MUL - 1);
            2'b11:   lat_c = CNT_W'(LAT_DIV - 1);
            default: lat_c = CNT_W'(LAT_ADD - 1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // A pop frees its slot only from the next cycle, since cmd_ready uses count_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + FCNT_W'(1);
                2'b01:   count_q <= count_q - FCNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_c_q     <= '0;
            rsp_op_q    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rsp_c_q     <= alu_c;
                        rsp_op_q    <= alu_op_q;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_DZ: begin
                    rsp_c_q     <= QNAN;
                    rsp_op_q    <= alu_op_q;
                    rsp_err_q   <= DZ_EN;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                end
            endcase
            // Issue overrides the transitions above (IDLE pop or back-to-back from RESP).
            if (pop_c) begin
                alu_a_q  <= head_c.a;
                alu_b_q  <= head_c.b;
                alu_op_q <= head_c.op;
                cnt_q    <= dz_c ? '0 : lat_c;
                state_q  <= dz_c ? S_DZ : S_WAIT;
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_err   = rsp_err_q;

endmodule
